// File: rtl/arith_mc_pkg.sv
// ---------------------------------------------------------------------------
// arith_mc_pkg
//   Shared definitions for the multi-cycle arithmetic machine: MIPS opcode and
//   funct encodings for the supported subset, ALU operation / FSM state /
//   immediate-extension enums, and the instruction decoder.
// ---------------------------------------------------------------------------
package arith_mc_pkg;

    // Primary opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    // R-type funct codes (instruction bits [5:0])
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR
    } alu_op_t;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALT
    } state_t;

    // EXT_NONE selects the rt register as the second ALU operand
    typedef enum logic [1:0] {
        EXT_NONE,
        EXT_SIGN,
        EXT_ZERO
    } ext_mode_t;

    typedef struct packed {
        logic      legal;
        alu_op_t   alu_op;
        ext_mode_t ext;
        logic      ovf_trap;  // signed overflow may trap (add/sub/addi only)
        logic      dest_rd;   // 1: write rd (R-type), 0: write rt (I-type)
    } decode_t;

    function automatic decode_t decode_instr(input logic [5:0] op,
                                             input logic [5:0] funct);
        decode_t d;
        d.legal    = 1'b0;
        d.alu_op   = ALU_ADD;
        d.ext      = EXT_NONE;
        d.ovf_trap = 1'b0;
        d.dest_rd  = 1'b0;
        if (op == OP_RTYPE) begin
            d.dest_rd = 1'b1;
            d.legal   = 1'b1;
            case (funct)
                FN_ADD:  begin d.alu_op = ALU_ADD; d.ovf_trap = 1'b1; end
                FN_ADDU: d.alu_op = ALU_ADD;
                FN_SUB:  begin d.alu_op = ALU_SUB; d.ovf_trap = 1'b1; end
                FN_SUBU: d.alu_op = ALU_SUB;
                FN_AND:  d.alu_op = ALU_AND;
                FN_OR:   d.alu_op = ALU_OR;
                FN_XOR:  d.alu_op = ALU_XOR;
                FN_NOR:  d.alu_op = ALU_NOR;
                default: d.legal = 1'b0;
            endcase
        end else begin
            d.legal = 1'b1;
            case (op)
                OP_ADDI:  begin d.alu_op = ALU_ADD; d.ext = EXT_SIGN; d.ovf_trap = 1'b1; end
                OP_ADDIU: begin d.alu_op = ALU_ADD; d.ext = EXT_SIGN; end
                OP_ANDI:  begin d.alu_op = ALU_AND; d.ext = EXT_ZERO; end
                OP_ORI:   begin d.alu_op = ALU_OR;  d.ext = EXT_ZERO; end
                OP_XORI:  begin d.alu_op = ALU_XOR; d.ext = EXT_ZERO; end
                default:  d.legal = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/arith_mc_alu.sv
// ---------------------------------------------------------------------------
// arith_mc_alu
//   Combinational ALU for the multi-cycle arithmetic machine.
//   Ports:
//     a, b            : DATA_WIDTH operands
//     alu_op          : operation select (alu_op_t)
//     result          : DATA_WIDTH result, wrapping arithmetic
//     signed_overflow : two's-complement overflow of ADD/SUB, 0 otherwise
// ---------------------------------------------------------------------------
module arith_mc_alu
    import arith_mc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  alu_op_t               alu_op,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  signed_overflow
);

    localparam int unsigned MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;

    always_comb begin
        sum  = a + b;
        diff = a - b;
    end

    always_comb begin
        result          = '0;
        signed_overflow = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                result = sum;
                // like-signed operands producing an opposite-signed sum
                signed_overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                result = diff;
                // unlike-signed operands where the difference loses a's sign
                signed_overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/arith_machine_mc.sv
// ---------------------------------------------------------------------------
// arith_machine_mc
//   Multi-cycle MIPS-subset arithmetic machine. Fetches one instruction per
//   valid-qualified memory handshake, executes R-type and I-type ALU
//   instructions against a 32-entry register file, and halts on an illegal
//   instruction or (optionally) on signed overflow.
//   Ports:
//     clock, reset   : rising-edge clock, synchronous active-high reset
//     imem_req       : fetch request (FETCH state, reset low)
//     imem_addr      : fetch address, equal to the PC
//     imem_valid     : instruction word valid this cycle
//     imem_data      : 32-bit instruction word
//     except         : sticky illegal-instruction / overflow-trap flag
//     halted         : machine is in HALT
//     retired        : saturating count of completed instructions
//     dbg_raddr      : debug register index
//     dbg_rdata      : combinational read of register dbg_raddr (r0 reads 0)
// ---------------------------------------------------------------------------
module arith_machine_mc
    import arith_mc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned PC_WIDTH      = 32,
    parameter logic [31:0] RESET_PC      = 32'h0040_0000,
    parameter int unsigned COUNT_WIDTH   = 16,
    parameter int unsigned TRAP_OVERFLOW = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_valid,
    input  logic [31:0]            imem_data,
    output logic                   except,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] retired,
    input  logic [4:0]             dbg_raddr,
    output logic [DATA_WIDTH-1:0]  dbg_rdata
);

    state_t state;
    state_t state_next;

    logic [PC_WIDTH-1:0]   pc;
    logic [31:0]           ir;
    logic [DATA_WIDTH-1:0] regs [32];

    // Instruction fields
    logic [5:0]  ir_op;
    logic [5:0]  ir_funct;
    logic [4:0]  ir_rs;
    logic [4:0]  ir_rt;
    logic [4:0]  ir_rd;
    logic [15:0] ir_imm;
    logic        unused_shamt;

    always_comb begin
        ir_op    = ir[31:26];
        ir_rs    = ir[25:21];
        ir_rt    = ir[20:16];
        ir_rd    = ir[15:11];
        ir_imm   = ir[15:0];
        ir_funct = ir[5:0];
    end

    // shamt has no meaning for the supported instruction subset
    assign unused_shamt = ^ir[10:6];

    decode_t               dec;
    logic [4:0]            dest;
    logic [DATA_WIDTH-1:0] opnd_a;
    logic [DATA_WIDTH-1:0] opnd_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_ovf;
    logic                  fault;

    always_comb begin
        dec    = decode_instr(ir_op, ir_funct);
        dest   = dec.dest_rd ? ir_rd : ir_rt;
        opnd_a = regs[ir_rs];
        case (dec.ext)
            EXT_SIGN: opnd_b = DATA_WIDTH'($signed(ir_imm));
            EXT_ZERO: opnd_b = DATA_WIDTH'(ir_imm);
            default:  opnd_b = regs[ir_rt];
        endcase
    end

    arith_mc_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .a               (opnd_a),
        .b               (opnd_b),
        .alu_op          (dec.alu_op),
        .result          (alu_result),
        .signed_overflow (alu_ovf)
    );

    always_comb begin
        fault = !dec.legal || ((TRAP_OVERFLOW != 0) && dec.ovf_trap && alu_ovf);
    end

    // Control: next state plus the per-cycle update strobes
    logic ir_load;
    logic commit;
    logic trap;

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        commit     = 1'b0;
        trap       = 1'b0;
        case (state)
            FETCH: begin
                // dropping the request during reset abandons any fetch
                imem_req = !reset;
                if (imem_valid) begin
                    ir_load    = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (fault) begin
                    trap       = 1'b1;
                    state_next = HALT;
                end else begin
                    commit     = 1'b1;
                    state_next = FETCH;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc      <= PC_WIDTH'(RESET_PC);
            ir      <= '0;
            except  <= 1'b0;
            retired <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ir_load) begin
                ir <= imem_data;
            end
            if (commit) begin
                pc <= pc + PC_WIDTH'(4);
                if (retired != '1) begin
                    retired <= retired + COUNT_WIDTH'(1);
                end
                if (dest != 5'd0) begin
                    regs[dest] <= alu_result;
                end
            end
            if (trap) begin
                except <= 1'b1;
            end
        end
    end

    always_comb begin
        imem_addr = pc;
        halted    = (state == HALT);
        dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];
    end

endmodule

// File: tb/tb_arith_machine_mc.sv
// ---------------------------------------------------------------------------
// tb_arith_machine_mc
//   Three configurations of arith_machine_mc run side by side: default with
//   trapping, a narrow 16-bit / 8-bit-PC / 2-bit-counter build, and a default
//   build with overflow wrapping. A per-instruction behavioural model tracks
//   each one; directed programs pin known values, then random programs with
//   random wait states and resets follow.
// ---------------------------------------------------------------------------
module tb_arith_machine_mc;

    localparam int NI = 3;

    logic clock = 1'b0;
    always #10 clock = ~clock;

    logic       rst [NI];
    logic       vld [NI];
    logic [31:0] dat [NI];
    logic [4:0] dra [NI];

    logic        req0, exc0, hlt0;
    logic [31:0] addr0, dbg0;
    logic [15:0] ret0;
    logic        req1, exc1, hlt1;
    logic [7:0]  addr1;
    logic [15:0] dbg1;
    logic [1:0]  ret1;
    logic        req2, exc2, hlt2;
    logic [31:0] addr2, dbg2;
    logic [15:0] ret2;

    arith_machine_mc #(.DATA_WIDTH(32), .PC_WIDTH(32), .RESET_PC(32'h0040_0000),
                       .COUNT_WIDTH(16), .TRAP_OVERFLOW(1)) dut0 (
        .clock(clock), .reset(rst[0]), .imem_req(req0), .imem_addr(addr0),
        .imem_valid(vld[0]), .imem_data(dat[0]), .except(exc0), .halted(hlt0),
        .retired(ret0), .dbg_raddr(dra[0]), .dbg_rdata(dbg0));

    arith_machine_mc #(.DATA_WIDTH(16), .PC_WIDTH(8), .RESET_PC(32'h0000_00FC),
                       .COUNT_WIDTH(2), .TRAP_OVERFLOW(0)) dut1 (
        .clock(clock), .reset(rst[1]), .imem_req(req1), .imem_addr(addr1),
        .imem_valid(vld[1]), .imem_data(dat[1]), .except(exc1), .halted(hlt1),
        .retired(ret1), .dbg_raddr(dra[1]), .dbg_rdata(dbg1));

    arith_machine_mc #(.DATA_WIDTH(32), .PC_WIDTH(32), .RESET_PC(32'h0040_0000),
                       .COUNT_WIDTH(16), .TRAP_OVERFLOW(0)) dut2 (
        .clock(clock), .reset(rst[2]), .imem_req(req2), .imem_addr(addr2),
        .imem_valid(vld[2]), .imem_data(dat[2]), .except(exc2), .halted(hlt2),
        .retired(ret2), .dbg_raddr(dra[2]), .dbg_rdata(dbg2));

    logic            o_req [NI];
    logic            o_exc [NI];
    logic            o_hlt [NI];
    longint unsigned o_addr [NI];
    longint unsigned o_ret [NI];
    longint unsigned o_dbg [NI];

    always_comb begin
        o_req[0] = req0; o_exc[0] = exc0; o_hlt[0] = hlt0;
        o_addr[0] = 64'(addr0); o_ret[0] = 64'(ret0); o_dbg[0] = 64'(dbg0);
        o_req[1] = req1; o_exc[1] = exc1; o_hlt[1] = hlt1;
        o_addr[1] = 64'(addr1); o_ret[1] = 64'(ret1); o_dbg[1] = 64'(dbg1);
        o_req[2] = req2; o_exc[2] = exc2; o_hlt[2] = hlt2;
        o_addr[2] = 64'(addr2); o_ret[2] = 64'(ret2); o_dbg[2] = 64'(dbg2);
    end

    // Configuration of each instance
    int              cfg_dw   [NI] = '{32, 16, 32};
    int              cfg_pw   [NI] = '{32, 8, 32};
    int              cfg_cw   [NI] = '{16, 2, 16};
    int              cfg_trap [NI] = '{1, 0, 0};
    longint unsigned cfg_rpc  [NI] = '{64'h0040_0000, 64'hFC, 64'h0040_0000};

    // Model: phase 0 = waiting for an instruction, 1 = holding one, 2 = halted
    int              m_phase [NI];
    longint unsigned m_pc    [NI];
    longint unsigned m_ret   [NI];
    longint unsigned m_regs  [NI][32];
    logic [31:0]     m_ir    [NI];
    bit              m_exc   [NI];

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   checking = 1'b0;
    bit   rand_mode = 1'b0;
    bit   stall = 1'b0;
    logic [31:0] prog [$];
    int   pidx [NI];

    function automatic longint unsigned mask(input int w);
        if (w >= 64) return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic longint sx(input longint unsigned v, input int w);
        if (((v >> (w - 1)) & 64'd1) != 0) return longint'(v) - (longint'(1) << w);
        return longint'(v);
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        int r, sel;
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        logic [5:0] op;
        r  = int'($urandom_range(0, 99));
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0: imm = 16'($urandom);
            1: imm = 16'($urandom_range(0, 15));
            2: imm = 16'h7FFF;
            default: imm = 16'h8000;
        endcase
        if (r < 2) return $urandom();
        if (r < 4) return itype(6'h0F, rt, rs, imm);
        if (r < 5) return rtype(6'h2A, rd, rs, rt);
        sel = int'($urandom_range(0, 12));
        if (sel < 8) return rtype(6'(32 + sel), rd, rs, rt);
        case (sel)
            8:  op = 6'h08;
            9:  op = 6'h09;
            10: op = 6'h0C;
            11: op = 6'h0D;
            default: op = 6'h0E;
        endcase
        return itype(op, rt, rs, imm);
    endfunction

    task automatic check(input string name, input int k,
                         input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t actual=0x%0h required=0x%0h",
                     name, k, $time, act, exp);
        end
    endtask

    // Architectural effect of one instruction, from the instruction-set rules
    task automatic m_exec(input int k);
        logic [31:0] ir;
        logic [5:0] op, fn;
        int rs, rt, rd, dest, w;
        longint unsigned mk, a, b, res;
        longint s;
        bit legal, chk, sub, ovf;
        ir = m_ir[k];
        w  = cfg_dw[k];
        mk = mask(w);
        op = ir[31:26];
        fn = ir[5:0];
        rs = int'(ir[25:21]);
        rt = int'(ir[20:16]);
        rd = int'(ir[15:11]);
        a = m_regs[k][rs];
        b = m_regs[k][rt];
        legal = 1; chk = 0; sub = 0; dest = rd; res = 0;
        if (op == 6'h00) begin
            case (fn)
                6'h20: begin res = a + b; chk = 1; end
                6'h21: res = a + b;
                6'h22: begin res = a - b; chk = 1; sub = 1; end
                6'h23: res = a - b;
                6'h24: res = a & b;
                6'h25: res = a | b;
                6'h26: res = a ^ b;
                6'h27: res = ~(a | b);
                default: legal = 0;
            endcase
        end else begin
            dest = rt;
            case (op)
                6'h08, 6'h09: begin
                    b = {{48{ir[15]}}, ir[15:0]} & mk;
                    res = a + b;
                    chk = (op == 6'h08);
                end
                6'h0C: res = a & {48'h0, ir[15:0]};
                6'h0D: res = a | {48'h0, ir[15:0]};
                6'h0E: res = a ^ {48'h0, ir[15:0]};
                default: legal = 0;
            endcase
        end
        res = res & mk;
        ovf = 0;
        if (chk) begin
            s = sub ? (sx(a, w) - sx(b, w)) : (sx(a, w) + sx(b, w));
            ovf = (s > ((longint'(1) << (w - 1)) - 1)) || (s < -(longint'(1) << (w - 1)));
        end
        if (!legal || (chk && ovf && cfg_trap[k] != 0)) begin
            m_exc[k] = 1;
            m_phase[k] = 2;
        end else begin
            if (dest != 0) m_regs[k][dest] = res;
            m_pc[k] = (m_pc[k] + 4) & mask(cfg_pw[k]);
            if (m_ret[k] != mask(cfg_cw[k])) m_ret[k]++;
            m_phase[k] = 0;
        end
    endtask

    task automatic model_update(input int k);
        if (rst[k]) begin
            m_pc[k] = cfg_rpc[k] & mask(cfg_pw[k]);
            for (int r = 0; r < 32; r++) m_regs[k][r] = 0;
            m_phase[k] = 0;
            m_exc[k] = 0;
            m_ret[k] = 0;
            m_ir[k] = 0;
        end else if (m_phase[k] == 0) begin
            if (vld[k]) begin
                m_ir[k] = dat[k];
                m_phase[k] = 1;
                if (!rand_mode && pidx[k] < prog.size()) pidx[k]++;
            end
        end else if (m_phase[k] == 1) begin
            m_exec(k);
        end
    endtask

    task automatic drive_directed();
        for (int k = 0; k < NI; k++) begin
            vld[k] = !stall && (pidx[k] < prog.size());
            dat[k] = (pidx[k] < prog.size()) ? prog[pidx[k]] : 32'h0;
        end
    endtask

    task automatic step();
        @(posedge clock);
        for (int k = 0; k < NI; k++) model_update(k);
        #2;
        for (int k = 0; k < NI; k++) dra[k] = 5'($urandom_range(0, 31));
        if (rand_mode) begin
            for (int k = 0; k < NI; k++) begin
                rst[k] = ($urandom_range(0, 499) == 0) ||
                         (m_phase[k] == 2 && $urandom_range(0, 3) == 0);
                vld[k] = ($urandom_range(0, 3) != 0);
                dat[k] = rand_instr();
            end
        end else begin
            drive_directed();
        end
    endtask

    task automatic do_reset();
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1;
            pidx[k] = 0;
        end
        drive_directed();
        step();
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        #1;
    endtask

    task automatic pin_reg(input string name, input int k, input int r,
                           input longint unsigned exp);
        dra[k] = 5'(r);
        #1;
        check(name, k, o_dbg[k], exp);
    endtask

    // Every cycle: all outputs of every instance against the model
    always @(negedge clock) begin
        if (checking) begin
            for (int k = 0; k < NI; k++) begin
                check("imem_req", k, 64'(o_req[k]), 64'(m_phase[k] == 0 && !rst[k]));
                check("imem_addr", k, o_addr[k], m_pc[k]);
                check("except", k, 64'(o_exc[k]), 64'(m_exc[k]));
                check("halted", k, 64'(o_hlt[k]), 64'(m_phase[k] == 2));
                check("retired", k, o_ret[k], m_ret[k]);
                check("dbg_rdata", k, o_dbg[k],
                      (dra[k] == 5'd0) ? 64'd0 : m_regs[k][dra[k]]);
            end
        end
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; vld[k] = 1'b0; dat[k] = 32'h0; dra[k] = 5'd0; pidx[k] = 0;
        end

        // Dependent adds with zero-wait memory
        prog = '{itype(6'h08, 1, 0, 16'd5), itype(6'h08, 2, 0, 16'hFFFD),
                 rtype(6'h20, 3, 1, 2)};
        do_reset();
        checking = 1'b1;
        repeat (6) step();
        pin_reg("t1_r3", 0, 3, 64'd2);
        pin_reg("t1_r2", 0, 2, 64'hFFFF_FFFD);
        check("t1_retired", 0, o_ret[0], 64'd3);
        check("t1_except", 0, 64'(o_exc[0]), 64'd0);
        check("t1_addr", 0, o_addr[0], 64'h0040_000C);
        pin_reg("t1_r2_w16", 1, 2, 64'hFFFD);
        check("t1_addr_w16", 1, o_addr[1], 64'h08);

        // Wait states during the second fetch
        prog = '{itype(6'h08, 1, 0, 16'd1), itype(6'h08, 2, 0, 16'd2)};
        do_reset();
        repeat (2) step();
        stall = 1'b1;
        drive_directed();
        repeat (4) step();
        check("t2_addr_stall", 0, o_addr[0], 64'h0040_0004);
        check("t2_ret_stall", 0, o_ret[0], 64'd1);
        stall = 1'b0;
        drive_directed();
        repeat (2) step();
        check("t2_ret_8cyc", 0, o_ret[0], 64'd2);
        pin_reg("t2_r2", 0, 2, 64'd2);

        // Illegal instruction halts; reset recovers
        prog = '{itype(6'h08, 1, 0, 16'd7), itype(6'h0F, 1, 0, 16'h1234)};
        do_reset();
        repeat (4) step();
        check("t3_except", 0, 64'(o_exc[0]), 64'd1);
        check("t3_halted", 0, 64'(o_hlt[0]), 64'd1);
        check("t3_retired", 0, o_ret[0], 64'd1);
        repeat (5) step();
        check("t3_req_held", 0, 64'(o_req[0]), 64'd0);
        pin_reg("t3_r1", 0, 1, 64'd7);
        do_reset();
        check("t3_rst_except", 0, 64'(o_exc[0]), 64'd0);
        check("t3_rst_halted", 0, 64'(o_hlt[0]), 64'd0);
        check("t3_rst_req", 0, 64'(o_req[0]), 64'd1);

        // Overflow: trapping add vs addu vs non-trapping build
        prog = '{itype(6'h09, 1, 0, 16'd1)};
        repeat (31) prog.push_back(rtype(6'h21, 1, 1, 1));
        prog.push_back(itype(6'h09, 1, 1, 16'hFFFF));
        prog.push_back(rtype(6'h20, 2, 1, 1));
        do_reset();
        repeat (68) step();
        check("t4_trap_except", 0, 64'(o_exc[0]), 64'd1);
        pin_reg("t4_r1", 0, 1, 64'h7FFF_FFFF);
        pin_reg("t4_r2_kept", 0, 2, 64'd0);
        pin_reg("t4_r2_wrap", 2, 2, 64'hFFFF_FFFE);
        check("t4_nowrap_except", 2, 64'(o_exc[2]), 64'd0);
        prog[33] = rtype(6'h21, 2, 1, 1);
        do_reset();
        repeat (68) step();
        pin_reg("t4_addu_r2", 0, 2, 64'hFFFF_FFFE);
        check("t4_addu_except", 0, 64'(o_exc[0]), 64'd0);

        // Logical immediates zero-extend; r0 stays zero
        prog = '{itype(6'h0D, 0, 0, 16'hFFFF), itype(6'h0E, 4, 0, 16'h8000),
                 rtype(6'h27, 5, 0, 0)};
        do_reset();
        repeat (6) step();
        pin_reg("t5_r0", 0, 0, 64'd0);
        pin_reg("t5_r4", 0, 4, 64'h0000_8000);
        pin_reg("t5_r5", 0, 5, 64'hFFFF_FFFF);
        pin_reg("t5_r5_w16", 1, 5, 64'hFFFF);

        // Narrow build: counter saturation, PC wrap, mid-fetch reset
        prog = {};
        repeat (5) prog.push_back(itype(6'h09, 1, 1, 16'd1));
        do_reset();
        repeat (2) step();
        check("t6_pc_wrap", 1, o_addr[1], 64'h00);
        check("t6_ret1", 1, o_ret[1], 64'd1);
        repeat (2) step();
        check("t6_pc_04", 1, o_addr[1], 64'h04);
        repeat (6) step();
        check("t6_ret_sat", 1, o_ret[1], 64'd3);
        check("t6_pc_end", 1, o_addr[1], 64'h10);
        pin_reg("t6_r1", 1, 1, 64'd5);
        rst[1] = 1'b1;
        vld[1] = 1'b1;
        dat[1] = itype(6'h09, 1, 1, 16'd1);
        step();
        rst[1] = 1'b0;
        #1;
        check("t6_rst_pc", 1, o_addr[1], 64'hFC);
        check("t6_rst_ret", 1, o_ret[1], 64'd0);
        repeat (2) step();

        // Random programs, wait states and resets
        rand_mode = 1'b1;
        repeat (4000) step();

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_machine_mc.md
Name: arith_machine_mc

Overview:
Parametrised multi-cycle successor to the single-cycle arithmetic machine.
- Fetches MIPS-format 32-bit instructions over a valid-qualified instruction-memory handshake, so memory may insert wait states.
- Executes R-type and I-type ALU instructions against an internal 32-entry register file.
- Configurable signed-overflow trapping.
- Exposes a sticky exception, a halt flag, a retired-instruction counter and a debug register read port for the CPU test benches.

Parameters:
DATA_WIDTH, 32, register/ALU width; legal range 16..64.
PC_WIDTH, 32, program counter width; PC wraps modulo 2^PC_WIDTH.
RESET_PC, 32'h0040_0000, PC value after reset, truncated to PC_WIDTH.
COUNT_WIDTH, 16, retired counter width.
TRAP_OVERFLOW, 1, 1 = signed overflow on add/sub/addi raises except; 0 = wrap and write.

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
imem_req  out  1  fetch request; high only in FETCH state and reset low.
imem_addr  out  PC_WIDTH  fetch address (= PC); stable while imem_req high.
imem_valid  in  1  instruction word valid this cycle; ignored when imem_req low.
imem_data  in  32  instruction word, sampled when imem_req & imem_valid.
except  out  1  sticky: illegal instruction or overflow trap occurred.
halted  out  1  machine in HALT state.
retired  out  COUNT_WIDTH  count of completed instructions, saturating.
dbg_raddr  in  5  debug register index.
dbg_rdata  out  DATA_WIDTH  combinational read of register dbg_raddr; reg 0 reads 0.

Behaviour:
- Reset (edge with reset=1) sets the following, with reset taking priority over every other event:
  - PC=RESET_PC, all 32 registers = 0, IR = 0.
  - state=FETCH, except=0, halted=0, retired=0.
- States: FETCH, EXEC, HALT.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - imem_valid=0: stay in FETCH with no state change (wait state).
  - imem_valid=1: IR<=imem_data, go to EXEC.
  - Zero-wait memory gives 2 cycles per instruction.
- EXEC: decode IR.
  - R-type (opcode 0x00), dest rd, funct: add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27. shamt ignored.
  - I-type, dest rt:
    - addi 0x08 and addiu 0x09 sign-extend imm16 to DATA_WIDTH.
    - andi 0x0C, ori 0x0D and xori 0x0E zero-extend imm16.
  - Legal, no trap: write result to dest (write to reg 0 discarded), PC<=PC+4, retired<=retired+1 (saturates at all-ones), go to FETCH.
  - Illegal opcode/funct: no register write, PC unchanged, retired unchanged, except<=1, halted<=1, go to HALT.
  - Overflow trap: add/sub/addi signed overflow at DATA_WIDTH with TRAP_OVERFLOW=1 is treated exactly as illegal, with no write.
  - addu/subu/addiu never trap.
- HALT: imem_req=0, state held until reset; except and halted stay 1.
- Source operands read the register file in EXEC. The write of instruction N commits before the EXEC of N+1, so no hazards exist.
- Reset asserted mid-FETCH with imem_req outstanding abandons the fetch; a late imem_valid is ignored because imem_req=0 during reset.
- PC+4 at 2^PC_WIDTH-4 wraps to 0.
- dbg_rdata reflects a write on the cycle after the writing EXEC edge.

Decomposition:
- Package arith_mc_pkg:
  - opcode and funct localparams.
  - ALU op enum (ADD, SUB, AND, OR, XOR, NOR).
  - state enum (FETCH, EXEC, HALT).
  - Immediate-extension mode enum.
- Sub-module arith_mc_alu (combinational):
  - inputs: A, B, alu_op, parametrised by DATA_WIDTH.
  - outputs: result, signed_overflow.
- Register file, decoder, FSM, PC and counter stay in the top module.

Test Plan:
1. Reset then zero-wait memory with addi $1,$0,5 ; addi $2,$0,-3 ; add $3,$1,$2 -> after 6 cycles dbg r3=2, r2=0xFFFFFFFD, retired=3, except=0, imem_addr=0x0040000C.
2. imem_valid held low 4 cycles during the second fetch -> imem_addr stable at 0x00400004, retired stays 1, then resumes. Total cycles for 2 instructions = 8.
3. lui $1 (opcode 0x0F) after one legal instruction -> next edge except=1, halted=1, retired=1, imem_req=0 forever. Registers unchanged; reset clears all flags.
4. TRAP_OVERFLOW=1: r1=0x7FFFFFFF, add $2,$1,$1 -> except=1, r2 unchanged. Same program with addu -> r2=0xFFFFFFFE, except=0. With TRAP_OVERFLOW=0, add writes 0xFFFFFFFE.
5. ori $0,$0,0xFFFF ; xori $4,$0,0x8000 ; nor $5,$0,$0 -> r0=0, r4=0x00008000 (zero-extended), r5=0xFFFFFFFF.
6. DATA_WIDTH=16, COUNT_WIDTH=2, PC_WIDTH=8, RESET_PC=8'hFC: five addiu -> retired saturates at 3 and PC wraps to 0x00 then 0x04. Reset asserted mid-FETCH -> PC=0xFC, retired=0 next cycle.
